// File: rtl/convolution_coprocessor_index_sequencer.sv
// rtl/convolution_coprocessor_index_sequencer.sv - index/control sequencer for the convolution coprocessor
// Walks output rows i and valid taps j, driving X/H read addresses and MAC/accumulator/Y-write strobes.

module convolution_coprocessor_comparatorLessThan #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);
    assign lt = (a < b);
endmodule

module convolution_coprocessor_index_sequencer #(
    parameter int DATA_WIDTH = 6,
    parameter int PIPE_LAT   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] sizeX_i,
    input  logic [DATA_WIDTH-1:0] sizeH_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] addrX_o,
    output logic [DATA_WIDTH-1:0] addrH_o,
    output logic                  mac_en_o,
    output logic                  acc_clear_o,
    output logic [DATA_WIDTH:0]   addrY_o,
    output logic                  y_we_o
);
    localparam int CW = $clog2(PIPE_LAT + 2);
    localparam logic [DATA_WIDTH:0]   ONE_W = 1;
    localparam logic [DATA_WIDTH-1:0] ONE_D = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] size_x, size_h, j;
    logic [DATA_WIDTH:0]   i, size_y;
    logic [CW-1:0]         drain_cnt;
    logic                  i_lt_h, i_lt_x;
    logic [DATA_WIDTH-1:0] j_start, j_end;
    logic                  last_tap, last_row;

    convolution_coprocessor_comparatorLessThan #(.WIDTH(DATA_WIDTH + 1)) u_lt_h (
        .a  (i),
        .b  ({1'b0, size_h}),
        .lt (i_lt_h)
    );

    convolution_coprocessor_comparatorLessThan #(.WIDTH(DATA_WIDTH + 1)) u_lt_x (
        .a  (i),
        .b  ({1'b0, size_x}),
        .lt (i_lt_x)
    );

    // When i >= sizeH the true j_start is < sizeX, so the low-bit modular result is exact.
    assign size_y   = {1'b0, size_x} + {1'b0, size_h} - ONE_W;
    assign j_start  = i_lt_h ? '0 : (i[DATA_WIDTH-1:0] - size_h + ONE_D);
    assign j_end    = i_lt_x ? i[DATA_WIDTH-1:0] : (size_x - ONE_D);
    assign last_tap = (j == j_end);
    assign last_row = (i == size_y - ONE_W);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        mac_en_o    = 1'b0;
        acc_clear_o = 1'b0;
        y_we_o      = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    if (sizeX_i != '0 && sizeH_i != '0) state_nxt = S_ROW;
                    else                                state_nxt = S_DONE;
                end
            end
            S_ROW: begin
                acc_clear_o = 1'b1;
                state_nxt   = S_MAC;
            end
            S_MAC: begin
                mac_en_o = 1'b1;
                if (last_tap) state_nxt = (PIPE_LAT == 0) ? S_WRITE : S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                y_we_o    = 1'b1;
                state_nxt = last_row ? S_DONE : S_ROW;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_x    <= '0;
            size_h    <= '0;
            i         <= '0;
            j         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        size_x <= sizeX_i;
                        size_h <= sizeH_i;
                        i      <= '0;
                    end
                end
                S_ROW:   j <= j_start;
                S_MAC: begin
                    if (!last_tap) j <= j + ONE_D;
                    else           drain_cnt <= CW'(PIPE_LAT - 1);
                end
                S_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
                end
                S_WRITE: begin
                    if (!last_row) i <= i + ONE_W;
                end
                default: ;
            endcase
        end
    end

    assign addrX_o = j;
    assign addrH_o = i[DATA_WIDTH-1:0] - j;
    assign addrY_o = i;

endmodule

// File: tb/tb_convolution_coprocessor_index_sequencer.sv
// tb/tb_convolution_coprocessor_index_sequencer.sv - self-checking bench for the convolution index sequencer
// Two instances (PIPE_LAT=2 and PIPE_LAT=0) are driven together and compared against a per-cycle trace model.

module tb_convolution_coprocessor_index_sequencer;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [DW-1:0] sx_in = '0, sh_in = '0;

    logic busy2, done2, mac2, clr2, we2, busy0, done0, mac0, clr0, we0;
    logic [DW-1:0] ax2, ah2, ax0, ah0;
    logic [DW:0]   ay2, ay0;

    always #5 clk = ~clk;

    convolution_coprocessor_index_sequencer #(.DATA_WIDTH(DW), .PIPE_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .sizeX_i(sx_in), .sizeH_i(sh_in),
        .busy_o(busy2), .done_o(done2), .addrX_o(ax2), .addrH_o(ah2), .mac_en_o(mac2),
        .acc_clear_o(clr2), .addrY_o(ay2), .y_we_o(we2)
    );

    convolution_coprocessor_index_sequencer #(.DATA_WIDTH(DW), .PIPE_LAT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .sizeX_i(sx_in), .sizeH_i(sh_in),
        .busy_o(busy0), .done_o(done0), .addrX_o(ax0), .addrH_o(ah0), .mac_en_o(mac0),
        .acc_clear_o(clr0), .addrY_o(ay0), .y_we_o(we0)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          mac;
        logic          clr;
        logic          we;
        logic [DW-1:0] ax;
        logic [DW-1:0] ah;
        logic [DW:0]   ay;
    } ov_t;

    ov_t a2, a0;
    assign a2 = {busy2, done2, mac2, clr2, we2, ax2, ah2, ay2};
    assign a0 = {busy0, done0, mac0, clr0, we0, ax0, ah0, ay0};

    ov_t q2[$];
    ov_t q0[$];
    int checks = 0;
    int errors = 0;
    int cur_sx = 0, cur_sh = 0;

    int cyc2, done_cyc2, mac_cnt2, we_cnt2, clr_cnt2, row_idx2, max_ay2;
    int row_macs2[8];
    int r3[$];
    int cyc0, done_cyc0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input bit which, input ov_t v);
        if (which) q0.push_back(v);
        else       q2.push_back(v);
    endtask

    // Expected cycle-by-cycle trace of one run: ROW, taps, drain, WRITE per row, then DONE.
    task automatic gen(input int lat, input int sx, input int sh, input bit which);
        ov_t v;
        int js, je;
        if (sx != 0 && sh != 0) begin
            for (int i = 0; i < sx + sh - 1; i++) begin
                js = (i < sh) ? 0 : i - sh + 1;
                je = (i < sx) ? i : sx - 1;
                v = '0; v.busy = 1'b1; v.clr = 1'b1; put(which, v);
                for (int j = js; j <= je; j++) begin
                    v = '0; v.busy = 1'b1; v.mac = 1'b1; v.ax = DW'(j); v.ah = DW'(i - j);
                    put(which, v);
                end
                for (int d = 0; d < lat; d++) begin
                    v = '0; v.busy = 1'b1; put(which, v);
                end
                v = '0; v.busy = 1'b1; v.we = 1'b1; v.ay = (DW+1)'(i); put(which, v);
            end
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1; put(which, v);
    endtask

    task automatic cmp(input string tag, input ov_t a, input ov_t e);
        chk({tag, " busy"}, int'(a.busy), int'(e.busy));
        chk({tag, " done"}, int'(a.done), int'(e.done));
        chk({tag, " mac_en"}, int'(a.mac), int'(e.mac));
        chk({tag, " acc_clear"}, int'(a.clr), int'(e.clr));
        chk({tag, " y_we"}, int'(a.we), int'(e.we));
        if (e.mac) begin
            chk({tag, " addrX"}, int'(a.ax), int'(e.ax));
            chk({tag, " addrH"}, int'(a.ah), int'(e.ah));
        end
        if (a.mac) begin
            chk({tag, " inv_x"}, int'(int'(a.ax) < cur_sx), 1);
            chk({tag, " inv_h"}, int'(int'(a.ah) < cur_sh), 1);
        end
        if (e.we) chk({tag, " addrY"}, int'(a.ay), int'(e.ay));
    endtask

    always @(negedge clk) begin
        ov_t e2, e0;
        if (!rst) begin
            e2 = (q2.size() > 0) ? q2.pop_front() : ov_t'(0);
            e0 = (q0.size() > 0) ? q0.pop_front() : ov_t'(0);
            cmp("lat2", a2, e2);
            cmp("lat0", a0, e0);
            cyc2++;
            cyc0++;
            if (done2) done_cyc2 = cyc2;
            if (done0) done_cyc0 = cyc0;
            if (clr2) begin clr_cnt2++; row_idx2++; end
            if (mac2) begin
                mac_cnt2++;
                if (row_idx2 >= 0 && row_idx2 < 8) row_macs2[row_idx2]++;
                if (row_idx2 == 3) r3.push_back(int'(ax2) * 100 + int'(ah2));
            end
            if (we2) begin
                we_cnt2++;
                if (int'(ay2) > max_ay2) max_ay2 = int'(ay2);
            end
        end
    end

    task automatic start_run(input int sx, input int sh);
        @(negedge clk);
        #1;
        sx_in = DW'(sx); sh_in = DW'(sh); start = 1'b1;
        cur_sx = sx; cur_sh = sh;
        cyc2 = 0; cyc0 = 0; done_cyc2 = -1; done_cyc0 = -1;
        mac_cnt2 = 0; we_cnt2 = 0; clr_cnt2 = 0; row_idx2 = -1; max_ay2 = -1;
        for (int r = 0; r < 8; r++) row_macs2[r] = 0;
        r3.delete();
        gen(2, sx, sh, 1'b0);
        gen(0, sx, sh, 1'b1);
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((q2.size() > 0 || q0.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", int'(n >= budget), 0);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " lat2 outputs"}, int'(a2), 0);
        chk({tag, " lat0 outputs"}, int'(a0), 0);
    endtask

    initial begin
        int rm[7];
        rm = '{1, 2, 3, 3, 3, 2, 1};

        repeat (2) @(negedge clk);
        #1 chk_all_zero("in_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        start_run(5, 3);
        wait_done(200);
        for (int r = 0; r < 7; r++) chk($sformatf("5x3 row%0d macs", r), row_macs2[r], rm[r]);
        chk("5x3 mac total", mac_cnt2, 15);
        chk("5x3 writes", we_cnt2, 7);
        chk("5x3 row3 taps", r3.size(), 3);
        if (r3.size() == 3) begin
            chk("5x3 row3 tap0", r3[0], 102);
            chk("5x3 row3 tap1", r3[1], 201);
            chk("5x3 row3 tap2", r3[2], 300);
        end
        chk("5x3 done cycle lat2", done_cyc2, 44);
        chk("5x3 done cycle lat0", done_cyc0, 30);

        start_run(1, 1);
        wait_done(50);
        chk("1x1 done cycle lat2", done_cyc2, 6);
        chk("1x1 done cycle lat0", done_cyc0, 4);
        chk("1x1 mac total", mac_cnt2, 1);

        start_run(0, 4);
        wait_done(50);
        chk("0x4 done cycle lat2", done_cyc2, 1);
        chk("0x4 done cycle lat0", done_cyc0, 1);
        chk("0x4 macs", mac_cnt2, 0);
        chk("0x4 clears", clr_cnt2, 0);
        chk("0x4 writes", we_cnt2, 0);

        start_run(63, 63);
        wait_done(6000);
        chk("63x63 writes", we_cnt2, 125);
        chk("63x63 macs", mac_cnt2, 3969);
        chk("63x63 last addrY", max_ay2, 124);

        start_run(5, 3);
        repeat (12) @(negedge clk);
        #2;
        chk("pre_reset mac_en", int'(mac2), 1);
        chk("pre_reset addrX", int'(ax2), 0);
        chk("pre_reset addrH", int'(ah2), 2);
        rst = 1'b1;
        q2.delete();
        q0.delete();
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        start_run(2, 2);
        repeat (3) @(negedge clk);
        #1;
        sx_in = 6'd7; sh_in = 6'd9; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done(100);
        chk("2x2 done cycle lat2", done_cyc2, 17);
        chk("2x2 writes", we_cnt2, 3);
        chk("2x2 macs", mac_cnt2, 4);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=%0t exp=finished", $time);
        $fatal(1);
    end

endmodule
